// File: rtl/sda_gmem_read_arbiter_pkg.sv
// Shared types and constants for the gmem read arbiter and its round-robin selector.
// The index-width helper keeps a 1-bit index when only one port exists.
package sda_gmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY      = 2'b00;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sda_gmem_read_arbiter_if.sv
// Read-path bundles: the vectorised requester side and the single gmem AXI read master.
// The master modport belongs to whoever issues AR and consumes R.
interface sda_req_rd_if #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_araddr;
  logic [NUM_PORTS*8-1:0]          req_arlen;
  logic [NUM_PORTS-1:0]            req_arvalid;
  logic [NUM_PORTS-1:0]            req_arready;
  logic [DATA_WIDTH-1:0]           req_rdata;
  logic [1:0]                      req_rresp;
  logic                            req_rlast;
  logic [NUM_PORTS-1:0]            req_rvalid;
  logic [NUM_PORTS-1:0]            req_rready;

  modport master (
    output req_araddr, req_arlen, req_arvalid, req_rready,
    input  req_arready, req_rdata, req_rresp, req_rlast, req_rvalid
  );

  modport slave (
    input  req_araddr, req_arlen, req_arvalid, req_rready,
    output req_arready, req_rdata, req_rresp, req_rlast, req_rvalid
  );
endinterface

interface sda_axi_rd_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] m_araddr;
  logic [7:0]            m_arlen;
  logic [2:0]            m_arsize;
  logic [1:0]            m_arburst;
  logic                  m_arvalid;
  logic                  m_arready;
  logic [DATA_WIDTH-1:0] m_rdata;
  logic [1:0]            m_rresp;
  logic                  m_rlast;
  logic                  m_rvalid;
  logic                  m_rready;

  modport master (
    output m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
    input  m_arready, m_rdata, m_rresp, m_rlast, m_rvalid
  );

  modport slave (
    input  m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
    output m_arready, m_rdata, m_rresp, m_rlast, m_rvalid
  );
endinterface

// File: rtl/sda_gmem_read_arbiter_rr_select.sv
// Combinational rotate-priority encoder: first set bit of req at or above ptr, wrapping.
// Kept generic so the write-channel arbiter can reuse it.
module sda_rr_select
  import sda_gmem_pkg::*;
#(
  parameter  int NUM_PORTS = 4,
  localparam int IDX_W     = idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [IDX_W-1:0]     sel,
  output logic                 found
);

  logic [NUM_PORTS-1:0] rot;
  logic [IDX_W:0]       sum;

  assign rot = NUM_PORTS'({req, req} >> ptr);

  // Scan downward so the lowest rotated position, i.e. closest to ptr, wins.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    sum   = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, ptr} + (IDX_W + 1)'(k);
        if (sum >= (IDX_W + 1)'(NUM_PORTS)) sum = sum - (IDX_W + 1)'(NUM_PORTS);
        sel   = sum[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/sda_gmem_read_arbiter.sv
// Round-robin sharing of the gmem AR/R read path between NUM_PORTS requesters,
// one outstanding burst at a time, with a sticky beat-count mismatch flag.
module sda_gmem_read_arbiter
  import sda_gmem_pkg::*;
#(
  parameter  int NUM_PORTS  = 4,
  parameter  int ADDR_WIDTH = 64,
  parameter  int DATA_WIDTH = 32,
  localparam int IDX_W      = idx_width(NUM_PORTS)
) (
  input  logic             clk,
  input  logic             reset,
  sda_req_rd_if.slave      req,
  sda_axi_rd_if.master     gmem,
  output logic [IDX_W-1:0] grant_idx,
  output logic             busy,
  output logic             len_err
);

  arb_state_e            state, state_n;
  logic [IDX_W-1:0]      rr_ptr, rr_n, grant_n, sel;
  logic                  found;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_n;
  logic [7:0]            arlen_q, arlen_n, beat_cnt, cnt_n;
  logic                  err_n;

  logic [ADDR_WIDTH-1:0] addr_arr [NUM_PORTS];
  logic [7:0]            len_arr  [NUM_PORTS];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
    assign addr_arr[i] = req.req_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign len_arr[i]  = req.req_arlen[i*8 +: 8];
  end

  sda_rr_select #(.NUM_PORTS(NUM_PORTS)) u_rr_select (
    .req   (req.req_arvalid),
    .ptr   (rr_ptr),
    .sel   (sel),
    .found (found)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      beat_cnt  <= '0;
      len_err   <= 1'b0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_n;
      grant_idx <= grant_n;
      araddr_q  <= araddr_n;
      arlen_q   <= arlen_n;
      beat_cnt  <= cnt_n;
      len_err   <= err_n;
    end
  end

  always_comb begin
    state_n          = state;
    rr_n             = rr_ptr;
    grant_n          = grant_idx;
    araddr_n         = araddr_q;
    arlen_n          = arlen_q;
    cnt_n            = beat_cnt;
    err_n            = len_err;
    req.req_arready  = '0;
    req.req_rvalid   = '0;
    gmem.m_rready    = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          req.req_arready[sel] = 1'b1;
          araddr_n = addr_arr[sel];
          arlen_n  = len_arr[sel];
          cnt_n    = len_arr[sel];
          grant_n  = sel;
          rr_n     = (sel == IDX_W'(NUM_PORTS - 1)) ? '0 : sel + 1'b1;
          state_n  = ADDR;
        end
      end
      ADDR: begin
        if (gmem.m_arready) state_n = DATA;
      end
      DATA: begin
        req.req_rvalid[grant_idx] = gmem.m_rvalid;
        gmem.m_rready = req.req_rready[grant_idx];
        // Counter holds remaining beats after this one; a missing RLAST keeps us here saturated at 0.
        if (gmem.m_rvalid && req.req_rready[grant_idx]) begin
          if (gmem.m_rlast ? (beat_cnt != 8'd0) : (beat_cnt == 8'd0)) err_n = 1'b1;
          if (beat_cnt != 8'd0) cnt_n = beat_cnt - 8'd1;
          if (gmem.m_rlast) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign gmem.m_arvalid  = (state == ADDR);
  assign gmem.m_araddr   = araddr_q;
  assign gmem.m_arlen    = arlen_q;
  assign gmem.m_arsize   = 3'($clog2(DATA_WIDTH / 8));
  assign gmem.m_arburst  = AXI_BURST_INCR;
  assign req.req_rdata   = gmem.m_rdata;
  assign req.req_rresp   = gmem.m_rresp;
  assign req.req_rlast   = gmem.m_rlast;
  assign busy            = (state != IDLE);

endmodule

// File: tb/tb_sda_gmem_read_arbiter.sv
// Randomised scenario bench for sda_gmem_read_arbiter against a burst-level model
// (round-robin pick by search, beat index vs ARLEN for the length flag).
module tb_sda_gmem_read_arbiter;
  import sda_gmem_pkg::*;

  localparam int N  = 4;
  localparam int AW = 64;
  localparam int DW = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] grant_idx;
  logic       busy, len_err;

  logic [AW-1:0] p_addr [N];
  logic [7:0]    p_len  [N];
  logic [N-1:0]  p_valid = '0;
  logic [N-1:0]  p_rready = '0;

  int checks = 0;
  int failures = 0;
  int m_rr = 0;
  bit m_err = 1'b0;
  int cur_len = 0;

  sda_req_rd_if #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) req_if ();
  sda_axi_rd_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) gmem_if ();

  sda_gmem_read_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req_if.slave),
    .gmem      (gmem_if.master),
    .grant_idx (grant_idx),
    .busy      (busy),
    .len_err   (len_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_if.req_araddr[i*AW +: AW] = p_addr[i];
      req_if.req_arlen[i*8 +: 8]    = p_len[i];
    end
    req_if.req_arvalid = p_valid;
    req_if.req_rready  = p_rready;
  end

  // Reference arbitration: first requesting port at or after the pointer, wrapping.
  function automatic int model_pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_rr = 0;
    m_err = 1'b0;
    #1;
  endtask

  // Address phase for whichever port the model says wins; leaves time in the first DATA cycle.
  task automatic accept_addr(input int delay, output int port);
    int exp;
    #1;
    exp = model_pick(p_valid, m_rr);
    port = exp;
    checks++;
    if (exp < 0) begin
      failures++;
      $display("[TB] FAIL grant_exists: no requester asserted, got none required one");
      return;
    end
    checks++;
    if (req_if.req_arready !== (N'(1) << exp) || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_arready: got %b busy=%b required %b busy=0", req_if.req_arready, busy, N'(1) << exp);
    end
    @(negedge clk);
    p_valid[exp] = 1'b0;
    cur_len = int'(p_len[exp]);
    m_rr = (exp + 1) % N;
    for (int c = 0; c <= delay; c++) begin
      if (c > 0) @(negedge clk);
      gmem_if.m_arready = (c == delay);
      gmem_if.m_rvalid  = 1'($urandom);
      p_rready = N'($urandom);
      #1;
      checks++;
      if (gmem_if.m_arvalid !== 1'b1 || gmem_if.m_araddr !== p_addr[exp] || gmem_if.m_arlen !== p_len[exp]) begin
        failures++;
        $display("[TB] FAIL addr_hold: got v=%b a=%h l=%0d required v=1 a=%h l=%0d", gmem_if.m_arvalid, gmem_if.m_araddr, gmem_if.m_arlen, p_addr[exp], p_len[exp]);
      end
      checks++;
      if (grant_idx !== 2'(exp) || busy !== 1'b1 || req_if.req_arready !== '0 || gmem_if.m_rready !== 1'b0 || req_if.req_rvalid !== '0) begin
        failures++;
        $display("[TB] FAIL addr_side: got g=%0d busy=%b arr=%b mrr=%b rv=%b required g=%0d busy=1 arr=0 mrr=0 rv=0", grant_idx, busy, req_if.req_arready, gmem_if.m_rready, req_if.req_rvalid, exp);
      end
    end
    @(negedge clk);
    gmem_if.m_arready = 1'b0;
    gmem_if.m_rvalid  = 1'b0;
    #1;
    checks++;
    if (gmem_if.m_arvalid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL addr_done: got arvalid=%b busy=%b required 0 1", gmem_if.m_arvalid, busy);
    end
  endtask

  // Beats are counted per handshake; RLAST goes out on handshake index last_at.
  task automatic data_phase(input int port, input int last_at, input logic [7:0] pat);
    int done = 0;
    int cyc = 0;
    int hs = 0;
    logic [DW-1:0] d;
    logic [1:0] resp;
    logic rdy;
    while (done <= last_at && cyc < 200) begin
      d = DW'($urandom);
      resp = 2'($urandom);
      rdy = pat[cyc % 8];
      gmem_if.m_rvalid = 1'b1;
      gmem_if.m_rdata  = d;
      gmem_if.m_rresp  = resp;
      gmem_if.m_rlast  = (done == last_at);
      p_rready = N'($urandom);
      p_rready[port] = rdy;
      #1;
      checks++;
      if (req_if.req_rvalid !== (N'(1) << port) || gmem_if.m_rready !== rdy) begin
        failures++;
        $display("[TB] FAIL data_route: got rvalid=%b mrready=%b required %b %b", req_if.req_rvalid, gmem_if.m_rready, N'(1) << port, rdy);
      end
      checks++;
      if (req_if.req_rdata !== d || req_if.req_rresp !== resp || req_if.req_rlast !== gmem_if.m_rlast) begin
        failures++;
        $display("[TB] FAIL data_pass: got %h/%b/%b required %h/%b/%b", req_if.req_rdata, req_if.req_rresp, req_if.req_rlast, d, resp, gmem_if.m_rlast);
      end
      checks++;
      if (len_err !== m_err || busy !== 1'b1) begin
        failures++;
        $display("[TB] FAIL data_state: got len_err=%b busy=%b required %b 1", len_err, busy, m_err);
      end
      if (gmem_if.m_rready === 1'b1) hs++;
      if (rdy) begin
        if (gmem_if.m_rlast ? (done < cur_len) : (done >= cur_len)) m_err = 1'b1;
        done++;
      end
      @(negedge clk);
      cyc++;
    end
    gmem_if.m_rvalid = 1'b0;
    gmem_if.m_rlast  = 1'b0;
    p_rready = '0;
    #1;
    checks++;
    if (hs !== last_at + 1) begin
      failures++;
      $display("[TB] FAIL beat_count: got %0d handshakes required %0d", hs, last_at + 1);
    end
    checks++;
    if (busy !== 1'b0 || len_err !== m_err || req_if.req_rvalid !== '0 || gmem_if.m_rready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL burst_end: got busy=%b len_err=%b rv=%b required 0 %b 0", busy, len_err, req_if.req_rvalid, m_err);
    end
  endtask

  task automatic test_reset();
    gmem_if.m_rvalid = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || len_err !== 1'b0 || grant_idx !== 2'd0 || gmem_if.m_arvalid !== 1'b0 || gmem_if.m_araddr !== '0 || gmem_if.m_arlen !== 8'd0) begin
      failures++;
      $display("[TB] FAIL reset_regs: got busy=%b err=%b g=%0d av=%b a=%h l=%0d required all zero", busy, len_err, grant_idx, gmem_if.m_arvalid, gmem_if.m_araddr, gmem_if.m_arlen);
    end
    checks++;
    if (req_if.req_arready !== '0 || req_if.req_rvalid !== '0 || gmem_if.m_rready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_hs: got arr=%b rv=%b mrr=%b required 0", req_if.req_arready, req_if.req_rvalid, gmem_if.m_rready);
    end
    checks++;
    if (gmem_if.m_arsize !== 3'd2 || gmem_if.m_arburst !== 2'b01) begin
      failures++;
      $display("[TB] FAIL ar_const: got size=%0d burst=%b required 2 01", gmem_if.m_arsize, gmem_if.m_arburst);
    end
    reset = 1'b0;
    gmem_if.m_rvalid = 1'b0;
    m_rr = 0;
    m_err = 1'b0;
  endtask

  task automatic test_single_port();
    int port;
    p_addr[2] = 64'h1000;
    p_len[2]  = 8'd3;
    p_valid   = 4'b0100;
    accept_addr(0, port);
    checks++;
    if (port != 2) begin
      failures++;
      $display("[TB] FAIL single_grant: got %0d required 2", port);
    end
    data_phase(2, 3, 8'hFF);
    checks++;
    if (len_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_err: got %b required 0", len_err);
    end
  endtask

  task automatic test_rr_order();
    int port;
    int order [5] = '{0, 1, 3, 0, 2};
    apply_reset();
    for (int i = 0; i < N; i++) begin
      p_addr[i] = 64'h2000 + 64'(i * 64'h100);
      p_len[i]  = 8'(i % 2);
    end
    p_valid = 4'b1011;
    for (int b = 0; b < 5; b++) begin
      accept_addr(0, port);
      checks++;
      if (port != order[b]) begin
        failures++;
        $display("[TB] FAIL rr_order%0d: got %0d required %0d", b, port, order[b]);
      end
      if (b == 2) p_valid = p_valid | 4'b0101;
      data_phase(port, cur_len, 8'hFF);
    end
  endtask

  task automatic test_addr_stall();
    int port;
    p_addr[1] = 64'hDEAD_BEEF_0000_0040;
    p_len[1]  = 8'd2;
    p_addr[3] = 64'h0000_0000_0000_3000;
    p_len[3]  = 8'd1;
    p_valid   = 4'b1010;
    accept_addr(5, port);
    data_phase(port, cur_len, 8'hFF);
    accept_addr(0, port);
    data_phase(port, cur_len, 8'hFF);
  endtask

  task automatic test_rready_toggle();
    int port;
    p_addr[0] = 64'h4000;
    p_len[0]  = 8'd3;
    p_valid   = 4'b0001;
    accept_addr(1, port);
    data_phase(port, 3, 8'b1001_1001);
  endtask

  task automatic test_len_err();
    int port;
    p_addr[1] = 64'h5000;
    p_len[1]  = 8'd3;
    p_valid   = 4'b0010;
    accept_addr(0, port);
    data_phase(port, 1, 8'hFF);
    checks++;
    if (len_err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL early_last: got %b required 1", len_err);
    end
    p_addr[2] = 64'h6000;
    p_len[2]  = 8'd0;
    p_valid   = 4'b0100;
    accept_addr(0, port);
    data_phase(port, 1, 8'hFF);
    checks++;
    if (len_err !== 1'b1) begin
      failures++;
      $display("[TB] FAIL missing_last: got %b required 1", len_err);
    end
  endtask

  task automatic test_reset_mid_burst();
    int port;
    p_addr[3] = 64'h7000;
    p_len[3]  = 8'd7;
    p_valid   = 4'b1000;
    accept_addr(0, port);
    gmem_if.m_rvalid = 1'b1;
    gmem_if.m_rlast  = 1'b0;
    p_rready = 4'b1000;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || len_err !== 1'b0 || grant_idx !== 2'd0 || gmem_if.m_arvalid !== 1'b0 || gmem_if.m_araddr !== '0 || gmem_if.m_arlen !== 8'd0) begin
      failures++;
      $display("[TB] FAIL midreset_regs: got busy=%b err=%b g=%0d av=%b a=%h l=%0d required all zero", busy, len_err, grant_idx, gmem_if.m_arvalid, gmem_if.m_araddr, gmem_if.m_arlen);
    end
    checks++;
    if (req_if.req_rvalid !== '0 || gmem_if.m_rready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_hs: got rv=%b mrr=%b required 0 0", req_if.req_rvalid, gmem_if.m_rready);
    end
    reset = 1'b0;
    gmem_if.m_rvalid = 1'b0;
    p_rready = '0;
    m_rr = 0;
    m_err = 1'b0;
    p_addr[1] = 64'h8000;
    p_len[1]  = 8'd0;
    p_addr[2] = 64'h9000;
    p_len[2]  = 8'd0;
    p_valid   = 4'b0110;
    accept_addr(0, port);
    checks++;
    if (port != 1) begin
      failures++;
      $display("[TB] FAIL midreset_grant: got %0d required 1", port);
    end
    data_phase(port, 0, 8'hFF);
    accept_addr(0, port);
    data_phase(port, 0, 8'hFF);
  endtask

  task automatic test_random();
    int port;
    int last;
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!p_valid[i] && ($urandom_range(0, 1) == 1)) begin
          p_addr[i]  = {32'($urandom), 32'($urandom)};
          p_len[i]   = 8'($urandom_range(0, 6));
          p_valid[i] = 1'b1;
        end
      end
      if (p_valid == '0) begin
        p_addr[0] = 64'hA000;
        p_len[0]  = 8'd1;
        p_valid   = 4'b0001;
      end
      accept_addr($urandom_range(0, 3), port);
      last = ($urandom_range(0, 3) == 0) ? $urandom_range(0, cur_len + 2) : cur_len;
      data_phase(port, last, 8'($urandom) | 8'h01);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      p_addr[i] = '0;
      p_len[i]  = '0;
    end
    gmem_if.m_arready = 1'b0;
    gmem_if.m_rvalid  = 1'b0;
    gmem_if.m_rlast   = 1'b0;
    gmem_if.m_rdata   = '0;
    gmem_if.m_rresp   = RESP_OKAY;
    test_reset();
    test_single_port();
    test_rr_order();
    test_addr_stall();
    test_rready_toggle();
    test_len_err();
    test_reset_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
